// File: rtl/hazard_scoreboard_unit.sv
// Operand-hazard controller: nearest-stage forwarding select per source operand,
// plus a scoreboard of multi-cycle producers that stalls dependent ID instructions.
module hazard_scoreboard_unit #(
    parameter int ADDR_W   = 5,
    parameter int NUM_SRC  = 2,
    parameter int NUM_FWD  = 2,
    parameter int SB_DEPTH = 4,
    parameter int LAT_W    = 3,
    parameter int CNT_W    = 16,
    parameter int SEL_W    = $clog2(NUM_FWD + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_SRC*ADDR_W-1:0]  EX_srcAddr_i,
    input  logic [NUM_FWD*ADDR_W-1:0]  FWD_wbAddr_i,
    input  logic [NUM_FWD-1:0]         FWD_regWrite_i,
    input  logic [NUM_SRC*ADDR_W-1:0]  ID_srcAddr_i,
    input  logic [NUM_SRC-1:0]         ID_srcUsed_i,
    input  logic                       ID_longOp_i,
    input  logic                       issue_valid_i,
    input  logic [ADDR_W-1:0]          issue_wbAddr_i,
    input  logic [LAT_W-1:0]           issue_lat_i,
    output logic [NUM_SRC*SEL_W-1:0]   Forward_o,
    output logic                       stall_o,
    output logic                       sb_full_o,
    output logic                       ovf_o,
    output logic [CNT_W-1:0]           stall_cnt_o
);

    logic [SB_DEPTH-1:0] valid_q;
    logic [ADDR_W-1:0]   addr_q [SB_DEPTH];
    logic [LAT_W-1:0]    cnt_q  [SB_DEPTH];
    logic                ovf_q;
    logic [CNT_W-1:0]    stall_cnt_q;

    logic [SB_DEPTH-1:0] alloc_oh;
    logic                alloc_req;
    logic                alloc_found;
    logic                sb_full;
    logic                src_hazard;

    // Forwarding: scan farthest to nearest so the nearest matching stage wins.
    always_comb begin
        Forward_o = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int s = NUM_FWD - 1; s >= 0; s--) begin
                if (FWD_regWrite_i[s] &&
                    (FWD_wbAddr_i[s*ADDR_W +: ADDR_W] != '0) &&
                    (FWD_wbAddr_i[s*ADDR_W +: ADDR_W] == EX_srcAddr_i[k*ADDR_W +: ADDR_W])) begin
                    Forward_o[k*SEL_W +: SEL_W] = SEL_W'(s + 1);
                end
            end
        end
    end

    assign sb_full   = &valid_q;
    assign alloc_req = issue_valid_i && (issue_lat_i != '0) && (issue_wbAddr_i != '0);

    // Lowest free entry judged on pre-edge state, so an entry freeing at this edge is not reused.
    always_comb begin
        alloc_oh    = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (!valid_q[i] && !alloc_found) begin
                alloc_oh[i] = 1'b1;
                alloc_found = 1'b1;
            end
        end
    end

    always_comb begin
        src_hazard = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                if (ID_srcUsed_i[k] && valid_q[i] &&
                    (ID_srcAddr_i[k*ADDR_W +: ADDR_W] != '0) &&
                    (addr_q[i] == ID_srcAddr_i[k*ADDR_W +: ADDR_W])) begin
                    src_hazard = 1'b1;
                end
            end
        end
    end

    assign stall_o = src_hazard || (ID_longOp_i && sb_full);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                addr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                if (alloc_req && alloc_oh[i]) begin
                    valid_q[i] <= 1'b1;
                    addr_q[i]  <= issue_wbAddr_i;
                    cnt_q[i]   <= issue_lat_i;
                end else if (valid_q[i]) begin
                    if (cnt_q[i] == LAT_W'(1)) begin
                        valid_q[i] <= 1'b0;
                    end
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ovf_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (alloc_req && sb_full) begin
                ovf_q <= 1'b1;
            end
            if (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign sb_full_o   = sb_full;
    assign ovf_o       = ovf_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: forwarding priority, scoreboard stalls,
// full/overflow behaviour, counter saturation and asynchronous reset.
module tb_hazard_scoreboard_unit;

    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;

    logic        clk;
    logic        rst_n;
    logic [9:0]  ex_src;
    logic [9:0]  fwd_addr;
    logic [1:0]  fwd_we;
    logic [9:0]  id_src;
    logic [1:0]  id_used;
    logic        id_long;
    logic        iss_v;
    logic [4:0]  iss_addr;
    logic [2:0]  iss_lat;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic        full;
    logic        ovf;
    logic [CNT_W-1:0] scnt;

    int errors = 0;
    int checks = 0;

    hazard_scoreboard_unit #(.ADDR_W(ADDR_W), .NUM_SRC(2), .NUM_FWD(2), .SB_DEPTH(4),
                             .LAT_W(3), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .EX_srcAddr_i(ex_src), .FWD_wbAddr_i(fwd_addr), .FWD_regWrite_i(fwd_we),
        .ID_srcAddr_i(id_src), .ID_srcUsed_i(id_used), .ID_longOp_i(id_long),
        .issue_valid_i(iss_v), .issue_wbAddr_i(iss_addr), .issue_lat_i(iss_lat),
        .Forward_o(fwd_sel), .stall_o(stall), .sb_full_o(full), .ovf_o(ovf),
        .stall_cnt_o(scnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ex_src = '0; fwd_addr = '0; fwd_we = '0;
        id_src = '0; id_used = '0; id_long = 1'b0;
        iss_v = 1'b0; iss_addr = '0; iss_lat = '0;
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        step();
    endtask

    task automatic issue(input logic [4:0] a, input logic [2:0] l);
        iss_v = 1'b1; iss_addr = a; iss_lat = l;
        step();
        iss_v = 1'b0; iss_addr = '0; iss_lat = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        checks++; if (scnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", scnt); end
    endtask

    task automatic test_forward();
        fwd_addr = {5'd3, 5'd3}; fwd_we = 2'b11; ex_src = {5'd0, 5'd3}; #1;
        checks++; if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL fwd_nearest got=%b exp=0001", fwd_sel); end
        fwd_we = 2'b10; #1;
        checks++; if (fwd_sel !== 4'b0010) begin errors++; $display("FAIL fwd_far got=%b exp=0010", fwd_sel); end
        ex_src = {5'd3, 5'd0}; fwd_we = 2'b11; #1;
        checks++; if (fwd_sel !== 4'b0100) begin errors++; $display("FAIL fwd_op1 got=%b exp=0100", fwd_sel); end
        fwd_addr = {5'd9, 5'd4}; ex_src = {5'd9, 5'd7}; #1;
        checks++; if (fwd_sel !== 4'b1000) begin errors++; $display("FAIL fwd_mixed got=%b exp=1000", fwd_sel); end
        fwd_addr = {5'd0, 5'd0}; ex_src = {5'd0, 5'd0}; #1;
        checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL fwd_r0 got=%b exp=0000", fwd_sel); end
        fwd_addr = {5'd3, 5'd3}; ex_src = {5'd3, 5'd3}; fwd_we = 2'b00; #1;
        checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL fwd_nowe got=%b exp=0000", fwd_sel); end
        fwd_we = 2'b00; fwd_addr = '0; ex_src = '0;
    endtask

    task automatic test_load_use();
        do_reset();
        id_src = {5'd0, 5'd5}; id_used = 2'b01;
        issue(5'd5, 3'd1);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL loaduse_stall got=%b exp=1", stall); end
        step();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL loaduse_release got=%b exp=0", stall); end
        checks++; if (scnt !== 4'd1) begin errors++; $display("FAIL loaduse_cnt got=%0d exp=1", scnt); end
        id_used = '0;
    endtask

    task automatic test_latency3();
        do_reset();
        id_src = {5'd7, 5'd0}; id_used = 2'b10;
        issue(5'd7, 3'd3);
        for (int c = 0; c < 3; c++) begin
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lat3_stall cyc=%0d got=%b exp=1", c, stall); end
            step();
        end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lat3_release got=%b exp=0", stall); end
        checks++; if (scnt !== 4'd3) begin errors++; $display("FAIL lat3_cnt got=%0d exp=3", scnt); end
        id_used = 2'b00;
        issue(5'd7, 3'd3);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lat3_unused got=%b exp=0", stall); end
        id_used = 2'b10; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lat3_used got=%b exp=1", stall); end
        id_used = 2'b00;
    endtask

    task automatic test_full();
        do_reset();
        issue(5'd1, 3'd7); issue(5'd2, 3'd7); issue(5'd3, 3'd7);
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_three got=%b exp=0", full); end
        issue(5'd4, 3'd7);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_four got=%b exp=1", full); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_nolong got=%b exp=0", stall); end
        id_long = 1'b1; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_long got=%b exp=1", stall); end
        id_long = 1'b0;
        issue(5'd9, 3'd7);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL full_ovf got=%b exp=1", ovf); end
        id_src = {5'd0, 5'd9}; id_used = 2'b01; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_dropped got=%b exp=0", stall); end
        id_src = {5'd0, 5'd1}; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_kept got=%b exp=1", stall); end
        id_used = '0;
    endtask

    task automatic test_same_edge();
        do_reset();
        issue(5'd1, 3'd4); issue(5'd2, 3'd7); issue(5'd3, 3'd7); issue(5'd4, 3'd7);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL same_full got=%b exp=1", full); end
        issue(5'd9, 3'd2);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL same_ovf got=%b exp=1", ovf); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL same_freed got=%b exp=0", full); end
        issue(5'd9, 3'd2);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL same_realloc got=%b exp=1", full); end
        id_src = {5'd0, 5'd9}; id_used = 2'b01; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL same_stall got=%b exp=1", stall); end
        id_used = '0;
    endtask

    task automatic test_saturate();
        do_reset();
        id_src = {5'd0, 5'd6}; id_used = 2'b01;
        for (int c = 0; c < 20; c++) issue(5'd6, 3'd1);
        checks++; if (scnt !== 4'd15) begin errors++; $display("FAIL sat_cnt got=%0d exp=15", scnt); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall got=%b exp=1", stall); end
        step();
        checks++; if (scnt !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", scnt); end
        id_used = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        issue(5'd1, 3'd7); issue(5'd2, 3'd7); issue(5'd3, 3'd7);
        id_src = {5'd0, 5'd1}; id_used = 2'b01; id_long = 1'b1;
        step(); step();
        checks++; if (scnt !== 4'd2) begin errors++; $display("FAIL arst_precnt got=%0d exp=2", scnt); end
        #2; rst_n = 1'b0; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL arst_stall got=%b exp=0", stall); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL arst_full got=%b exp=0", full); end
        checks++; if (scnt !== 4'd0) begin errors++; $display("FAIL arst_cnt got=%0d exp=0", scnt); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL arst_ovf got=%b exp=0", ovf); end
        rst_n = 1'b1;
        id_used = '0; id_long = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b1;
        test_reset();
        test_forward();
        test_load_use();
        test_latency3();
        test_full();
        test_same_edge();
        test_saturate();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
